// File: rtl/sync_fifo.sv
// Single-clock FIFO of DEPTH x WIDTH words with registered read data and full/empty flags.
// Latency: a word written at edge N can be read at edge N+1 (data_out updates at the read edge).
// Backpressure: writes while full are dropped unless a read frees a slot in the same cycle;
//               reads while empty are ignored.
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - synchronous reset, ACTIVE HIGH (name kept for port compatibility)
//   read      - read request
//   write     - write request, qualifies data_in
//   data_in   - write data
//   data_out  - registered read data, holds last word read
//   full      - DEPTH words stored
//   empty     - no words stored
//   overflow  - (SYNC_FIFO_ERR_FLAGS_EN only) one-cycle pulse after a dropped write
//   underflow - (SYNC_FIFO_ERR_FLAGS_EN only) one-cycle pulse after a read while empty
//
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN adds the overflow/underflow outputs.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             read,
  input  logic             write,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic rd_en;
  logic wr_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A read is accepted whenever data is present. A write is accepted when
  // there is room, or when full but a simultaneous read frees the oldest slot.
  assign rd_en = read && !empty;
  assign wr_en = write && (!full || rd_en);

  // Storage is not reset; stale entries are never visible because reads are
  // gated by count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      // When full with read+write, wr_ptr == rd_ptr: the nonblocking read
      // below still returns the old word before the slot is overwritten.
      if (rd_en) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= write && full && !rd_en;
      underflow <= read && empty;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed boundary cases with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based reference model.

module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;

  logic             clk;
  logic             rst_n;
  logic             read;
  logic             write;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .write    (write),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf;
  logic             m_unf;
  bit               chk_en;
  int               sz;
  bit               do_rd;
  bit               do_wr;

  always @(posedge clk) begin
    if (rst_n) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      sz    = q.size();
      do_rd = read && (sz > 0);
      do_wr = write && ((sz < DEPTH) || do_rd);
      m_ovf = write && (sz == DEPTH) && !do_rd;
      m_unf = read && (sz == 0);
      if (do_rd) m_dout = q.pop_front();
      if (do_wr) q.push_back(data_in);
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sb_data_out", 32'(data_out), 32'(m_dout));
      chk("sb_full",     32'(full),     32'(q.size() == DEPTH));
      chk("sb_empty",    32'(empty),    32'(q.size() == 0));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("sb_overflow",  32'(overflow),  32'(m_ovf));
      chk("sb_underflow", 32'(underflow), 32'(m_unf));
`endif
    end
  end

  // Drive one cycle: inputs set after a falling edge, held across the rising
  // edge, returns at the next falling edge with outputs settled.
  task automatic cyc(input logic r, input logic w, input logic [WIDTH-1:0] d);
    read    = r;
    write   = w;
    data_in = d;
    @(posedge clk);
    @(negedge clk);
    read    = 1'b0;
    write   = 1'b0;
  endtask

  logic [WIDTH-1:0] ord [5];
  int               wprob;

  initial begin
    rst_n   = 1'b1;
    read    = 1'b0;
    write   = 1'b0;
    data_in = '0;
    chk_en  = 1'b0;
    @(negedge clk);
    repeat (3) cyc(1'b0, 1'b0, '0);
    rst_n  = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_dout",  32'(data_out), 32'h00);

    // Ordered traffic
    ord[0] = 8'hFF; ord[1] = 8'hAA; ord[2] = 8'hCC; ord[3] = 8'h11; ord[4] = 8'h1F;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, ord[i]);
    chk("ord_not_empty", 32'(empty), 32'd0);
    chk("model_size5", 32'(q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("ord_dout", 32'(data_out), 32'(ord[i]));
    end
    chk("ord_empty", 32'(empty), 32'd1);

    // Empty boundary: reads ignored, data_out holds
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("emp_dout_hold", 32'(data_out), 32'h1F);
      chk("emp_empty", 32'(empty), 32'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("emp_underflow", 32'(underflow), 32'd1);
`endif
    end

    // Full boundary
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, WIDTH'(i));
      if (i == DEPTH - 2) chk("full_not_yet", 32'(full), 32'd0);
    end
    chk("full_set", 32'(full), 32'd1);
    chk("model_size64", 32'(q.size()), 32'd64);
    cyc(1'b0, 1'b1, 8'hEE);
    chk("full_drop_full", 32'(full), 32'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("full_overflow", 32'(overflow), 32'd1);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("full_rd_dout", 32'(data_out), 32'(i));
      if (i == 0) chk("full_fall", 32'(full), 32'd0);
    end
    chk("full_drain_empty", 32'(empty), 32'd1);

    // Simultaneous read/write while empty: only write accepted
    cyc(1'b1, 1'b1, 8'h5A);
    chk("sim_emp_dout", 32'(data_out), 32'h3F);
    chk("sim_emp_empty", 32'(empty), 32'd0);
    cyc(1'b1, 1'b0, '0);
    chk("sim_emp_rd", 32'(data_out), 32'h5A);
    chk("sim_emp_cnt1", 32'(empty), 32'd1);

    // Simultaneous read/write while full: both accepted
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, WIDTH'(8'h40 + i));
    cyc(1'b1, 1'b1, 8'hEE);
    chk("sim_full_dout", 32'(data_out), 32'h40);
    chk("sim_full_full", 32'(full), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("sim_full_order", 32'(data_out), (i == DEPTH) ? 32'hEE : 32'(8'h40 + i));
    end
    chk("sim_full_empty", 32'(empty), 32'd1);

    // Randomized traffic with occasional reset; write bias varies by phase
    wprob = 50;
    for (int c = 0; c < 1000; c++) begin
      if (c % 100 == 0) wprob = $urandom_range(20, 85);
      rst_n = ($urandom_range(0, 99) == 0);
      cyc(1'($urandom_range(0, 99) >= wprob), 1'($urandom_range(0, 99) < wprob),
          WIDTH'($urandom));
      rst_n = 1'b0;
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
